// File: rtl/fmq_cmd_pkg.sv
// Shared definitions for the FMQ command transmitter: command codes, FSM states and frame helpers.
package fmq_cmd_pkg;

  localparam logic [1:0] CMD_SET_OFFSET = 2'b00;
  localparam logic [1:0] CMD_RELOAD     = 2'b01;
  localparam logic [1:0] CMD_QUERY      = 2'b10;
  localparam logic [1:0] CMD_DAC        = 2'b11;

  // Only the first byte of a frame carries a set MSB, so the board can resynchronise on it.
  localparam logic FRAME_START = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND0,
    ST_SEND1,
    ST_SEND2,
    ST_WAIT_RESP
  } state_t;

  function automatic logic [7:0] frame_head(input logic [1:0] cmd, input logic [4:0] f);
    return {FRAME_START, cmd, f};
  endfunction

endpackage

// File: rtl/fmq_cmd_pack.sv
// Combinational packing of one command's fields into its three frame bytes B0/B1/B2.
module fmq_cmd_pack
  import fmq_cmd_pkg::*;
#(
  parameter int unsigned OFFSET_WIDTH = 11
) (
  input  logic [1:0]            cmd,
  input  logic [6:0]            addr,
  input  logic [OFFSET_WIDTH:0] offset,
  input  logic                  dac_sel,
  input  logic [7:0]            dac_val,
  output logic [7:0]            b0,
  output logic [7:0]            b1,
  output logic [7:0]            b2
);

  logic [4:0] f;
  logic [6:0] g;
  logic [6:0] h;

  // RELOAD and QUERY carry no payload, so their fields stay zero.
  always_comb begin
    f = '0;
    g = '0;
    h = '0;
    case (cmd)
      CMD_SET_OFFSET: begin
        f = addr[6:2];
        g = {addr[1:0], offset[OFFSET_WIDTH -: 5]};
        h = offset[6:0];
      end
      CMD_DAC: begin
        f = {dac_sel, 4'b0000};
        g = {6'b000000, dac_val[7]};
        h = dac_val[6:0];
      end
      default: ;
    endcase
  end

  assign b0 = frame_head(cmd, f);
  assign b1 = {1'b0, g};
  assign b2 = {1'b0, h};

endmodule

// File: rtl/fmq_cmd_tx.sv
// Command framer/transmitter for the FMQ transducer board, with query response capture.
// Define FMQ_CMD_AUTO_RELOAD_EN to follow every SET_OFFSET with an automatic RELOAD frame.
module fmq_cmd_tx
  import fmq_cmd_pkg::*;
#(
  parameter int unsigned OUTPUTS      = 88,
  parameter int unsigned OFFSET_WIDTH = 11,
  parameter int unsigned RESP_TIMEOUT = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_cmd,
  input  logic [6:0]            req_addr,
  input  logic [OFFSET_WIDTH:0] req_offset,
  input  logic                  req_dac_sel,
  input  logic [7:0]            req_dac_val,
  output logic [7:0]            m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  input  logic [7:0]            s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [7:0]            resp_data,
  output logic                  resp_valid,
  output logic                  resp_timeout,
  output logic                  err_addr,
  output logic                  stray
);

`ifdef FMQ_CMD_AUTO_RELOAD_EN
  localparam bit AUTO_RELOAD = 1'b1;
`else
  localparam bit AUTO_RELOAD = 1'b0;
`endif

  localparam int CNT_W = $clog2(RESP_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESP_TIMEOUT - 1);

  state_t                state;
  logic [1:0]            cmd_q;
  logic [6:0]            addr_q;
  logic [OFFSET_WIDTH:0] offset_q;
  logic                  dac_sel_q;
  logic [7:0]            dac_val_q;
  logic [CNT_W-1:0]      wait_cnt;

  logic [1:0]            pk_cmd;
  logic [6:0]            pk_addr;
  logic [OFFSET_WIDTH:0] pk_offset;
  logic                  pk_dac_sel;
  logic [7:0]            pk_dac_val;
  logic [7:0]            pk_b0;
  logic [7:0]            pk_b1;
  logic [7:0]            pk_b2;

  logic accept;
  logic addr_bad;
  logic tx_done;

  assign req_ready = (state == ST_IDLE) && !rst;
  assign s_tready  = 1'b1;
  assign accept    = req_valid && req_ready;
  assign addr_bad  = (req_cmd == CMD_SET_OFFSET) && (32'(req_addr) >= OUTPUTS);
  assign tx_done   = m_tvalid && m_tready;

  // B0 is loaded on the accept edge, before the request fields reach their registers.
  assign pk_cmd     = (state == ST_IDLE) ? req_cmd     : cmd_q;
  assign pk_addr    = (state == ST_IDLE) ? req_addr    : addr_q;
  assign pk_offset  = (state == ST_IDLE) ? req_offset  : offset_q;
  assign pk_dac_sel = (state == ST_IDLE) ? req_dac_sel : dac_sel_q;
  assign pk_dac_val = (state == ST_IDLE) ? req_dac_val : dac_val_q;

  fmq_cmd_pack #(
    .OFFSET_WIDTH(OFFSET_WIDTH)
  ) u_pack (
    .cmd    (pk_cmd),
    .addr   (pk_addr),
    .offset (pk_offset),
    .dac_sel(pk_dac_sel),
    .dac_val(pk_dac_val),
    .b0     (pk_b0),
    .b1     (pk_b1),
    .b2     (pk_b2)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cmd_q        <= '0;
      addr_q       <= '0;
      offset_q     <= '0;
      dac_sel_q    <= 1'b0;
      dac_val_q    <= '0;
      wait_cnt     <= '0;
      m_tdata      <= '0;
      m_tvalid     <= 1'b0;
      resp_data    <= '0;
      resp_valid   <= 1'b0;
      resp_timeout <= 1'b0;
      err_addr     <= 1'b0;
      stray        <= 1'b0;
    end else begin
      resp_valid   <= 1'b0;
      resp_timeout <= 1'b0;
      err_addr     <= 1'b0;
      stray        <= s_tvalid && (state != ST_WAIT_RESP);
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cmd_q     <= req_cmd;
            addr_q    <= req_addr;
            offset_q  <= req_offset;
            dac_sel_q <= req_dac_sel;
            dac_val_q <= req_dac_val;
            if (addr_bad) begin
              err_addr <= 1'b1;
            end else begin
              m_tdata  <= pk_b0;
              m_tvalid <= 1'b1;
              state    <= ST_SEND0;
            end
          end
        end
        ST_SEND0: begin
          if (tx_done) begin
            m_tdata <= pk_b1;
            state   <= ST_SEND1;
          end
        end
        ST_SEND1: begin
          if (tx_done) begin
            m_tdata <= pk_b2;
            state   <= ST_SEND2;
          end
        end
        ST_SEND2: begin
          if (tx_done) begin
            // Re-enter the send path as a payload-free RELOAD so B1/B2 pack to zero.
            if (AUTO_RELOAD && (cmd_q == CMD_SET_OFFSET)) begin
              cmd_q   <= CMD_RELOAD;
              m_tdata <= frame_head(CMD_RELOAD, 5'b00000);
              state   <= ST_SEND0;
            end else if (cmd_q == CMD_QUERY) begin
              m_tvalid <= 1'b0;
              wait_cnt <= '0;
              state    <= ST_WAIT_RESP;
            end else begin
              m_tvalid <= 1'b0;
              state    <= ST_IDLE;
            end
          end
        end
        ST_WAIT_RESP: begin
          if (s_tvalid) begin
            resp_data  <= s_tdata;
            resp_valid <= 1'b1;
            state      <= ST_IDLE;
          end else if (wait_cnt == CNT_LAST) begin
            resp_timeout <= 1'b1;
            state        <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/fmq_cmd_tx.md
FMQ_CMD_TX -- requirements
Module: fmq_cmd_tx

Interface
REQ-001 SHALL have parameter OUTPUTS, default 88, meaning the number of transducer channels addressable on the target board.
REQ-002 SHALL have parameter OFFSET_WIDTH, default 11, meaning the phase offset width; the offset field is OFFSET_WIDTH+1 bits, the MSB being the channel enable.
REQ-003 SHALL have parameter RESP_TIMEOUT, default 50000, meaning the maximum number of cycles to wait for a query response.
REQ-004 SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have ports req_valid, input, 1 bit, and req_ready, output, 1 bit: the command request handshake.
REQ-007 SHALL have port req_cmd, input, 2 bits: 00 SET_OFFSET, 01 RELOAD, 10 QUERY, 11 DAC.
REQ-008 SHALL have ports req_addr (input, 7 bits: channel), req_offset (input, 12 bits: {enable, offset}), req_dac_sel (input, 1 bit: 1 = divisor, 0 = value) and req_dac_val (input, 8 bits).
REQ-009 SHALL have ports m_tdata (output, 8 bits), m_tvalid (output, 1 bit) and m_tready (input, 1 bit): the byte stream to the UART transmitter.
REQ-010 SHALL have ports s_tdata (input, 8 bits), s_tvalid (input, 1 bit) and s_tready (output, 1 bit): the byte stream from the UART receiver.
REQ-011 SHALL have outputs resp_data (8 bits), resp_valid, resp_timeout, err_addr and stray, each a 1-cycle pulse except resp_data.

Function
REQ-012 SHALL drive req_ready high only in state IDLE; a request is accepted on the cycle req_valid and req_ready are both high, and all request fields SHALL be registered on that cycle.
REQ-013 SHALL, for SET_OFFSET with req_addr >= OUTPUTS, pulse err_addr the next cycle, emit no bytes and remain in IDLE.
REQ-014 SHALL frame each command as three bytes, sent in order B0, B1, B2.
- B0 = {1, cmd[1:0], f[4:0]}.
- B1 = {0, g[6:0]}.
- B2 = {0, h[6:0]}.
REQ-015 SHALL fill the fields for SET_OFFSET as f=addr[6:2], g={addr[1:0], offset[11:7]}, h=offset[6:0].
REQ-016 SHALL fill the fields for DAC as f={dac_sel, 0000}, g={000000, val[7]}, h=val[6:0].
REQ-017 SHALL set f, g and h to zero for RELOAD and QUERY.
REQ-018 SHALL step through states IDLE -> SEND0 -> SEND1 -> SEND2 -> IDLE, or SEND2 -> WAIT_RESP when the command is QUERY.
REQ-019 SHALL assert m_tvalid with B0 on the cycle after acceptance; each byte SHALL be held stable while m_tvalid is high and m_tready is low; the next byte SHALL be presented on the cycle after the handshake, giving a minimum of 3 cycles per command.
REQ-020 SHALL, in WAIT_RESP, capture the first s_tvalid byte into resp_data, pulse resp_valid and return to IDLE.
REQ-021 SHALL, if no byte arrives in WAIT_RESP within RESP_TIMEOUT cycles, pulse resp_timeout and return to IDLE; a byte arriving on the timeout cycle SHALL win.
REQ-022 SHALL hold s_tready permanently high and discard any byte received outside WAIT_RESP, pulsing stray.

Reset
REQ-023 SHALL, while rst is high, force state IDLE and drive the following outputs.
- req_ready 0.
- m_tvalid 0, m_tdata 0.
- resp_data 0.
- All pulse outputs 0.
- Timeout counter cleared.
REQ-024 SHALL abandon any in-flight command on reset with no partial completion; req_ready SHALL rise on the first cycle after rst falls.

Configuration
REQ-025 SHALL, when FMQ_CMD_AUTO_RELOAD_EN is defined, follow every SET_OFFSET with an automatic RELOAD frame (A0 00 00) before returning to IDLE, keeping req_ready low throughout.
REQ-026 SHALL, when FMQ_CMD_AUTO_RELOAD_EN is undefined, send only the requested frame.

Structure
REQ-027 SHALL take the following from shared package fmq_cmd_pkg.
- Command code constants.
- FSM state type.
- Frame start-bit constant.
REQ-028 SHALL place byte packing in one combinational sub-module fmq_cmd_pack (fields in, B0/B1/B2 out); fmq_cmd_tx holds the FSM, counter and registers.

Verification
REQ-029 SHALL verify SET_OFFSET addr=85, offset=0xABC -> bytes 0x95, 0x35, 0x3C, then idle, with m_tready held at 1.
REQ-030 SHALL verify DAC sel=0 val=0xFF -> 0xE0, 0x01, 0x7F; DAC sel=1 val=0x80 -> 0xF0, 0x01, 0x00.
REQ-031 SHALL verify QUERY -> 0xC0, 0x00, 0x00; s_tdata=0x58 driven 10 cycles later -> resp_valid with resp_data=0x58; with no response, resp_timeout exactly RESP_TIMEOUT cycles after the B2 handshake.
REQ-032 SHALL verify m_tready low for 5 cycles during B1 -> m_tdata=B1 and m_tvalid stable throughout, with no byte lost or duplicated.
REQ-033 SHALL verify SET_OFFSET addr=88 -> err_addr pulse and no m_tvalid; and rst asserted during SEND1 -> m_tvalid=0 next cycle, with IDLE after release.
REQ-034 SHALL verify, with FMQ_CMD_AUTO_RELOAD_EN defined, SET_OFFSET addr=0 offset=0 -> 0x80, 0x00, 0x00, 0xA0, 0x00, 0x00.
